alu_link_initiator: RTL and testbench
=====================================

Name: alu_link_initiator

Overview:
- Host-side initiator for the 5-byte-request / 3-byte-response ALU link carried over the UART byte interface.
- Accepts one ALU request (op, a, b) on a valid/ready port and serialises it through a uart instance's TX handshake.
- Collects the 3-byte reply from the uart RX strobe and presents it as a single-cycle response.
- Sits between test/control logic and a uart instance on the far end of the link from the ALU responder.

Parameters:
- DATA_W, 16, operand/result width; fixed at 2 bytes per operand.
- TIMEOUT_CYCLES, 1000000, CLK cycles allowed between response bytes (only used with ALU_RSP_TIMEOUT_EN).
- TO_CNT_W, 20, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST_N  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; transfer when req_valid & req_ready
- req_op  input  2  ALU opcode
- req_a  input  16  operand A
- req_b  input  16  operand B
- rsp_valid  output  1  one-cycle pulse, response fields valid
- rsp_res  output  16  result, held until next rsp_valid
- rsp_overflow  output  1  overflow flag, held
- rsp_timeout  output  1  response aborted by timeout, held
- busy  output  1  high in any state except IDLE
- TXbuffer  output  8  byte to uart transmitter
- TXstart  output  1  one-cycle start strobe to uart
- TXbusy  input  1  uart transmitter busy
- RXbuffer  input  8  received byte from uart
- RXready  input  1  one-cycle strobe, RXbuffer valid

Behaviour:
- Reset (async, RST_N low): state IDLE; TXbuffer=0, TXstart=0, rsp_valid=0, rsp_res=0, rsp_overflow=0, rsp_timeout=0, busy=0, req_ready=1 after release. Reset mid-transfer aborts with no rsp_valid; the partially sent frame is abandoned.
- Request capture: on req_valid & req_ready, latch op/a/b, byte index=0, go to TX_LOAD. Latency to first TXstart is 1 cycle if TXbusy is low.
- TX byte order: 0 = {6'b0, op}, 1 = a[7:0], 2 = a[15:8], 3 = b[7:0], 4 = b[15:8].
- TX_LOAD:
  - If TXbusy=0, drive TXbuffer=byte[idx] and TXstart=1 for exactly one cycle, then go to TX_ACK.
  - If TXbusy=1, hold TXstart=0 and wait.
- TX_ACK: wait until TXbusy is sampled 1, then go to TX_DONE. TXbuffer is held stable.
- TX_DONE: wait until TXbusy=0.
  - If idx=4, go to RX with rx index=0.
  - Otherwise idx+1 and go to TX_LOAD.
- RXready strobes in any TX state or in IDLE are ignored and dropped.
- RX: each RXready stores RXbuffer into slot rxidx (0 = res[7:0], 1 = res[15:8], 2 = overflow byte).
  - On the third byte, the next cycle is RSP: rsp_valid=1 for one cycle, rsp_res={b1,b0}, rsp_overflow=b2[0], rsp_timeout=0. b2[7:1] is ignored.
  - RSP then goes to IDLE; req_ready=1 on the following cycle.
- Back-to-back: a req_valid held high is accepted on the first IDLE cycle after RSP. Minimum 1 IDLE cycle between frames.
- Simultaneous RSP and req_valid: the request is not accepted until IDLE.

Optional Feature:
- Macro: ALU_RSP_TIMEOUT_EN.
- Defined:
  - Counter is cleared on entry to RX and on every RXready in RX; it increments each cycle otherwise.
  - On reaching TIMEOUT_CYCLES-1 it emits RSP with rsp_timeout=1, rsp_res=0, rsp_overflow=0, then returns to IDLE.
  - A late byte after the timeout is dropped.
- Undefined:
  - No counter; RX waits indefinitely.
  - rsp_timeout is tied 0; TIMEOUT_CYCLES and TO_CNT_W are unused.

Decomposition:
- Package alu_link_pkg:
  - state encoding (IDLE, TX_LOAD, TX_ACK, TX_DONE, RX, RSP)
  - REQ_BYTES=5, RSP_BYTES=3
  - opcode constants ADD/SUB/AND/OR = 2'd0..3
- One natural sub-module, uart_tx_sequencer: owns the TX_LOAD/TX_ACK/TX_DONE handshake.
  - Inputs: byte plus a send strobe.
  - Outputs: TXbuffer, TXstart, byte_done.
  - It is reused by the responder side.

Test Plan:
- Reset during TX of byte 2 (RST_N low 3 cycles) -> TXstart=0, busy=0, req_ready=1; no rsp_valid pulse, and the next request starts from byte 0.
- Request op=1, a=16'h1234, b=16'h0F0F, uart model with 10-cycle busy -> TX bytes 01,34,12,0F,0F, each TXstart exactly 1 cycle and only when TXbusy=0.
- RX stream 25,03,01 after frame -> one rsp_valid, rsp_res=16'h0325, rsp_overflow=1, rsp_timeout=0; outputs hold after the pulse.
- Inject RXready=AA during TX phase, then 00,00,00 -> AA dropped; rsp_res=0, rsp_overflow=0.
- Model holds TXbusy=1 for 50 cycles at request time -> no TXstart until TXbusy falls, then 1-cycle start.
- With ALU_RSP_TIMEOUT_EN and TIMEOUT_CYCLES=100, send only 1 response byte -> rsp_valid with rsp_timeout=1, rsp_res=0 about 100 cycles later, then IDLE. Without the macro -> stays in RX with busy=1.

Source files
------------

// File: rtl/alu_link_pkg.sv
// Shared types and constants for the 5-byte-request / 3-byte-response ALU link.
package alu_link_pkg;

  typedef enum logic [2:0] {IDLE, TX_LOAD, TX_ACK, TX_DONE, RX, RSP} link_state_t;

  localparam int REQ_BYTES = 5;
  localparam int RSP_BYTES = 3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } alu_req_t;

  // Wire order of the request frame: opcode, then both operands low byte first.
  function automatic logic [7:0] frame_byte(input alu_req_t r, input logic [2:0] idx);
    case (idx)
      3'd0:    frame_byte = {6'b0, r.op};
      3'd1:    frame_byte = r.a[7:0];
      3'd2:    frame_byte = r.a[15:8];
      3'd3:    frame_byte = r.b[7:0];
      default: frame_byte = r.b[15:8];
    endcase
  endfunction

endpackage

// File: rtl/alu_link_initiator_uart_tx_sequencer.sv
// One-byte uart TX handshake: load/start, wait for busy to rise, wait for busy to fall.
module uart_tx_sequencer
  import alu_link_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       TXbusy,
  output logic [7:0] TXbuffer,
  output logic       TXstart,
  output logic       byte_done
);

  link_state_t st, st_nx;
  logic        take;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st       <= IDLE;
      TXbuffer <= 8'h00;
    end else begin
      st <= st_nx;
      if (take) TXbuffer <= tx_byte;
    end
  end

  // A pending send is chained straight from TX_DONE so bytes go out back to back.
  always_comb begin
    st_nx     = st;
    take      = 1'b0;
    TXstart   = 1'b0;
    byte_done = 1'b0;
    case (st)
      IDLE: if (send) begin
        take  = 1'b1;
        st_nx = TX_LOAD;
      end
      TX_LOAD: if (!TXbusy) begin
        TXstart = 1'b1;
        st_nx   = TX_ACK;
      end
      TX_ACK: if (TXbusy) st_nx = TX_DONE;
      TX_DONE: if (!TXbusy) begin
        byte_done = 1'b1;
        take      = send;
        st_nx     = send ? TX_LOAD : IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/alu_link_initiator.sv
// Host-side ALU link initiator: serialises one request over uart TX, collects the 3-byte reply.
// Optional response timeout enabled by defining ALU_RSP_TIMEOUT_EN.
module alu_link_initiator
  import alu_link_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_CNT_W       = 20
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_overflow,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [7:0]        TXbuffer,
  output logic              TXstart,
  input  logic              TXbusy,
  input  logic [7:0]        RXbuffer,
  input  logic              RXready
);

  localparam logic [2:0] LAST_TX = 3'(REQ_BYTES - 1);
  localparam logic [1:0] LAST_RX = 2'(RSP_BYTES - 1);

  if (DATA_W != 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << TO_CNT_W)) begin : g_param_chk
    $error("alu_link_initiator: DATA_W must be 16 and TIMEOUT_CYCLES must fit TO_CNT_W");
  end

  link_state_t state, state_nx;
  alu_req_t    req_in, req_q;
  logic [2:0]  idx;
  logic [1:0]  rx_idx;
  logic [7:0]  rx_lo, rx_hi;
  logic        send, byte_done, to_hit;
  logic [7:0]  tx_byte;
  logic        last_tx, rx_last, rx_enter;

  assign req_in    = '{op: req_op, a: req_a, b: req_b};
  assign last_tx   = (idx == LAST_TX);
  assign rx_last   = (rx_idx == LAST_RX);
  assign rx_enter  = (state == TX_LOAD) && byte_done && last_tx;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RSP);

  uart_tx_sequencer u_txseq (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .send     (send),
    .tx_byte  (tx_byte),
    .TXbusy   (TXbusy),
    .TXbuffer (TXbuffer),
    .TXstart  (TXstart),
    .byte_done(byte_done)
  );

`ifdef ALU_RSP_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt;

  assign to_hit = (state == RX) && !RXready && (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      to_cnt      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (rx_enter || (state == RX && RXready)) to_cnt <= '0;
      else if (state == RX)                     to_cnt <= to_cnt + 1'b1;
      if (state == RX && RXready && rx_last) rsp_timeout <= 1'b0;
      else if (to_hit)                       rsp_timeout <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  // TX_LOAD stands for the whole request-byte loop; the sequencer tracks the handshake phase.
  always_comb begin
    state_nx = state;
    send     = 1'b0;
    tx_byte  = frame_byte(req_q, idx + 3'd1);
    case (state)
      IDLE: begin
        send    = req_valid;
        tx_byte = frame_byte(req_in, 3'd0);
        if (req_valid) state_nx = TX_LOAD;
      end
      TX_LOAD: begin
        send = !last_tx;
        if (rx_enter) state_nx = RX;
      end
      RX:      if ((RXready && rx_last) || to_hit) state_nx = RSP;
      RSP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_q        <= '0;
      idx          <= 3'd0;
      rx_idx       <= 2'd0;
      rx_lo        <= 8'h00;
      rx_hi        <= 8'h00;
      rsp_res      <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        req_q <= req_in;
        idx   <= 3'd0;
      end
      if (state == TX_LOAD && byte_done && !last_tx) idx <= idx + 3'd1;
      if (rx_enter) rx_idx <= 2'd0;
      if (state == RX && RXready) begin
        rx_idx <= rx_idx + 2'd1;
        case (rx_idx)
          2'd0: rx_lo <= RXbuffer;
          2'd1: rx_hi <= RXbuffer;
          default: begin
            rsp_res      <= {rx_hi, rx_lo};
            rsp_overflow <= RXbuffer[0];
          end
        endcase
      end else if (to_hit) begin
        rsp_res      <= '0;
        rsp_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_link_initiator.sv
// Randomised self-checking bench for alu_link_initiator with a simple uart TX busy model.
module tb_alu_link_initiator;
  import alu_link_pkg::*;

  logic        CLK, RST_N;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_overflow, rsp_timeout, busy;
  logic [15:0] rsp_res;
  logic [7:0]  TXbuffer, RXbuffer;
  logic        TXstart, TXbusy, RXready;

  alu_link_initiator #(.DATA_W(16), .TIMEOUT_CYCLES(100), .TO_CNT_W(20)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
    .busy(busy), .TXbuffer(TXbuffer), .TXstart(TXstart), .TXbusy(TXbusy),
    .RXbuffer(RXbuffer), .RXready(RXready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        to;
  } rsp_t;

  int checks = 0, failures = 0;
  logic [7:0] tx_log[$];
  rsp_t       rsp_q[$];
  int tx_base = 0, rsp_rd = 0;
  int busy_len = 10, busy_cnt = 0, start_cnt = 0, start_seen = 0;
  bit hold_busy = 1'b0;
  int start_viol = 0, double_viol = 0, rsp_double = 0;
  bit prev_start = 1'b0, prev_rsp = 1'b0;

  // Monitor: log every start strobe and response pulse mid-cycle.
  always @(negedge CLK) begin
    if (TXstart) begin
      if (TXbusy) start_viol++;
      if (prev_start) double_viol++;
      tx_log.push_back(TXbuffer);
      start_cnt++;
    end
    prev_start = TXstart;
    if (rsp_valid) begin
      if (prev_rsp) rsp_double++;
      rsp_q.push_back('{rsp_res, rsp_overflow, rsp_timeout});
    end
    prev_rsp = rsp_valid;
  end

  // Uart transmitter model: busy for busy_len cycles after each start.
  always @(posedge CLK) begin
    #1;
    if (start_cnt != start_seen) begin
      start_seen = start_cnt;
      busy_cnt   = busy_len;
    end
    TXbusy = hold_busy || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  end

  task automatic wait_tx(input int n, input string tag);
    for (int i = 0; i < 4000 && tx_log.size() < tx_base + n; i++) @(negedge CLK);
    checks++;
    if (tx_log.size() < tx_base + n) begin
      failures++;
      $display("FAIL %s tx_wait: got %0d bytes, need %0d", tag, tx_log.size() - tx_base, n);
    end
  endtask

  task automatic wait_rsp(input string tag, output int cyc, output bit ok);
    cyc = 0;
    while (cyc < 2000 && rsp_q.size() <= rsp_rd) begin
      @(negedge CLK);
      cyc++;
    end
    ok = (rsp_q.size() > rsp_rd);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s rsp_wait: no rsp_valid within %0d cycles", tag, cyc);
    end
  endtask

  task automatic do_request(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                            input string tag);
    bit got = 1'b0;
    tx_base = tx_log.size();
    @(posedge CLK); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge CLK);
      if (req_ready) got = 1'b1;
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s accept: req_ready=%b, required 1", tag, req_ready);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge CLK); #1;
    RXbuffer = b; RXready = 1'b1;
    @(posedge CLK); #1;
    RXready = 1'b0;
  endtask

  task automatic check_frame(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                             input string tag);
    logic [39:0] frame;
    frame = {b, a, 6'b0, op};
    for (int i = 0; i < REQ_BYTES; i++) begin
      checks++;
      if (tx_log[tx_base + i] !== frame[8*i +: 8]) begin
        failures++;
        $display("FAIL %s tx_byte%0d: got %h, required %h", tag, i, tx_log[tx_base + i], frame[8*i +: 8]);
      end
    end
  endtask

  task automatic check_rsp(input logic [15:0] res, input logic ovf, input logic to, input string tag);
    rsp_t r;
    r = rsp_q[rsp_rd];
    rsp_rd++;
    checks++;
    if (r.res !== res || r.ovf !== ovf || r.to !== to) begin
      failures++;
      $display("FAIL %s rsp: got res=%h ovf=%b to=%b, required res=%h ovf=%b to=%b",
               tag, r.res, r.ovf, r.to, res, ovf, to);
    end
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                         input int len, input bit inject, input string tag);
    int cyc; bit ok;
    busy_len = len;
    do_request(op, a, b, tag);
    wait_tx(2, tag);
    if (inject) send_rx(8'hAA);
    wait_tx(REQ_BYTES, tag);
    check_frame(op, a, b, tag);
    repeat (len + 4) @(posedge CLK);
    send_rx(r0);
    repeat ($urandom_range(0, 3)) @(posedge CLK);
    send_rx(r1);
    repeat ($urandom_range(0, 3)) @(posedge CLK);
    send_rx(r2);
    wait_rsp(tag, cyc, ok);
    if (ok) check_rsp({r1, r0}, r2[0], 1'b0, tag);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #12;
    checks++;
    if ({TXbuffer, TXstart, rsp_valid, rsp_res, rsp_overflow, rsp_timeout, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got TXbuffer=%h TXstart=%b rsp_valid=%b res=%h ovf=%b to=%b busy=%b, required all 0",
               TXbuffer, TXstart, rsp_valid, rsp_res, rsp_overflow, rsp_timeout, busy);
    end
    #10 RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got req_ready=%b busy=%b, required 1/0", req_ready, busy);
    end
  endtask

  task automatic test_frame();
    int cyc;
    run_txn(OP_SUB, 16'h1234, 16'h0F0F, 8'h25, 8'h03, 8'h01, 10, 1'b0, "frame");
    repeat (3) @(negedge CLK);
    cyc = rsp_q.size() - rsp_rd;
    checks++;
    if (rsp_res !== 16'h0325 || rsp_overflow !== 1'b1 || rsp_valid !== 1'b0 || cyc != 0) begin
      failures++;
      $display("FAIL frame_hold: got res=%h ovf=%b valid=%b extra=%0d, required 0325/1/0/0",
               rsp_res, rsp_overflow, rsp_valid, cyc);
    end
  endtask

  task automatic test_drop();
    run_txn(2'($urandom), 16'($urandom), 16'($urandom), 8'h00, 8'h00, 8'h00, 6, 1'b1, "drop");
  endtask

  task automatic test_busy_hold();
    int cyc; bit ok;
    hold_busy = 1'b1;
    repeat (2) @(posedge CLK);
    busy_len = 5;
    do_request(OP_ADD, 16'hBEEF, 16'h5A5A, "hold");
    repeat (50) @(negedge CLK);
    checks++;
    if (tx_log.size() != tx_base || busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_nostart: got %0d starts busy=%b, required 0 starts busy=1", tx_log.size() - tx_base, busy);
    end
    hold_busy = 1'b0;
    wait_tx(REQ_BYTES, "hold");
    check_frame(OP_ADD, 16'hBEEF, 16'h5A5A, "hold");
    repeat (10) @(posedge CLK);
    send_rx(8'h11); send_rx(8'h22); send_rx(8'hFE);
    wait_rsp("hold", cyc, ok);
    if (ok) check_rsp(16'h2211, 1'b0, 1'b0, "hold");
  endtask

  task automatic test_mid_reset();
    int n;
    busy_len = 10;
    do_request(OP_AND, 16'h7777, 16'h8888, "midrst");
    wait_tx(3, "midrst");
    @(negedge CLK); #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (TXstart !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: got TXstart=%b busy=%b, required 0/0", TXstart, busy);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    n = rsp_q.size();
    repeat (15) @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_q.size() != n || n != rsp_rd) begin
      failures++;
      $display("FAIL midrst_idle: got req_ready=%b busy=%b rsp_pulses=%0d, required 1/0/0",
               req_ready, busy, rsp_q.size() - rsp_rd);
    end
    rsp_rd = rsp_q.size();
    run_txn(OP_OR, 16'h0102, 16'h0304, 8'h99, 8'h88, 8'h03, 4, 1'b0, "midrst_next");
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      run_txn(2'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(1, 12), (t % 3) == 0, $sformatf("rand%0d", t));
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    int cyc; bit ok;
    logic [15:0] a1, b1, a2, b2;
    a1 = 16'($urandom); b1 = 16'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
    busy_len = 3;
    tx_base = tx_log.size();
    @(posedge CLK); #1;
    req_valid = 1'b1; req_op = OP_OR; req_a = a1; req_b = b1;
    wait_tx(1, "b2b");
    req_op = OP_AND; req_a = a2; req_b = b2;
    wait_tx(REQ_BYTES, "b2b");
    check_frame(OP_OR, a1, b1, "b2b1");
    repeat (8) @(posedge CLK);
    send_rx(8'h5A); send_rx(8'hC3); send_rx(8'h00);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rsp_cycle: got seen=%b req_ready=%b, required 1/0", seen, req_ready);
    end
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_cycle: got req_ready=%b busy=%b, required 1/0", req_ready, busy);
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b1 || TXstart !== 1'b1 || TXbuffer !== {6'b0, OP_AND}) begin
      failures++;
      $display("FAIL b2b_restart: got busy=%b TXstart=%b TXbuffer=%h, required 1/1/%h",
               busy, TXstart, TXbuffer, {6'b0, OP_AND});
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    wait_rsp("b2b1", cyc, ok);
    if (ok) check_rsp(16'hC35A, 1'b0, 1'b0, "b2b1");
    tx_base = tx_base + REQ_BYTES;
    wait_tx(REQ_BYTES, "b2b2");
    check_frame(OP_AND, a2, b2, "b2b2");
    repeat (8) @(posedge CLK);
    send_rx(8'h01); send_rx(8'h80); send_rx(8'h01);
    wait_rsp("b2b2", cyc, ok);
    if (ok) check_rsp(16'h8001, 1'b1, 1'b0, "b2b2");
  endtask

  task automatic test_timeout();
    int cyc; bit ok;
    busy_len = 4;
    do_request(OP_ADD, 16'h4321, 16'h1111, "timeout");
    wait_tx(REQ_BYTES, "timeout");
    repeat (8) @(posedge CLK);
    send_rx(8'h42);
`ifdef ALU_RSP_TIMEOUT_EN
    wait_rsp("timeout", cyc, ok);
    if (ok) check_rsp(16'h0000, 1'b0, 1'b1, "timeout");
    checks++;
    if (cyc < 90 || cyc > 115) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles, required about 100", cyc);
    end
    send_rx(8'h77);
    repeat (20) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_q.size() != rsp_rd) begin
      failures++;
      $display("FAIL timeout_idle: got busy=%b req_ready=%b extra=%0d, required 0/1/0",
               busy, req_ready, rsp_q.size() - rsp_rd);
    end
`else
    repeat (300) @(negedge CLK);
    checks++;
    if (busy !== 1'b1 || rsp_q.size() != rsp_rd || rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_wait: got busy=%b pulses=%0d to=%b, required 1/0/0",
               busy, rsp_q.size() - rsp_rd, rsp_timeout);
    end
    send_rx(8'h24); send_rx(8'h01);
    wait_rsp("no_timeout", cyc, ok);
    if (ok) check_rsp(16'h2442, 1'b1, 1'b0, "no_timeout");
`endif
  endtask

  task automatic test_protocol();
    checks++;
    if (start_viol != 0 || double_viol != 0 || rsp_double != 0) begin
      failures++;
      $display("FAIL protocol: got start_while_busy=%0d long_start=%0d long_rsp=%0d, required 0/0/0",
               start_viol, double_viol, rsp_double);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_op = 2'd0; req_a = 16'h0; req_b = 16'h0;
    RXbuffer = 8'h00; RXready = 1'b0; TXbusy = 1'b0;
    test_reset();
    test_frame();
    test_drop();
    test_busy_hold();
    test_mid_reset();
    test_random();
    test_back_to_back();
    test_timeout();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
